// File: rtl/reset_sequencer_pkg.sv
// Shared types and defaults for the SoC reset sequencer: state encoding,
// default timing constants and the per-state reset-net levels.
package reset_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_WAIT_LOCK = 3'd0,
      ST_DDR_RST   = 3'd1,
      ST_DDR_CALIB = 3'd2,
      ST_RUN       = 3'd3,
      ST_SOFT_RST  = 3'd4,
      ST_ERR       = 3'd5
   } seq_state_t;

   localparam int unsigned LOCK_FILTER_CYCLES_DEF = 16;
   localparam int unsigned RST_HOLD_CYCLES_DEF    = 32;
   localparam int unsigned DDR_TIMEOUT_CYCLES_DEF = 1048576;
   localparam logic [7:0]  SOFT_RST_CNT_MAX       = 8'd255;

   function automatic int unsigned maxOf3(input int unsigned a,
                                          input int unsigned b,
                                          input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

   // Reset-net levels {sys, dbg, ddr} held while in each state (1 = released).
   function automatic logic [2:0] nrstLevels(input seq_state_t s);
      case (s)
         ST_WAIT_LOCK: return 3'b000;
         ST_DDR_RST:   return 3'b010;
         ST_DDR_CALIB: return 3'b011;
         ST_RUN:       return 3'b111;
         ST_SOFT_RST:  return 3'b011;
         ST_ERR:       return 3'b010;
         default:      return 3'b000;
      endcase
   endfunction

endpackage

// File: rtl/cdc_sync2.sv
// Two-flop synchronizer for a single asynchronous level, cleared to 0 by the
// asynchronous active-low reset.
module cdc_sync2
   import reset_sequencer_pkg::*;
(
   input  logic i_clk,
   input  logic i_nrst,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_sync;

   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/reset_sequencer.sv
// Power-up and run-time reset sequencer: filtered PLL lock, DDR reset pulse,
// calibration wait with timeout, then system release; services soft resets.
module reset_sequencer
   import reset_sequencer_pkg::*;
#(
   parameter int unsigned LOCK_FILTER_CYCLES = LOCK_FILTER_CYCLES_DEF,
   parameter int unsigned RST_HOLD_CYCLES    = RST_HOLD_CYCLES_DEF,
   parameter int unsigned DDR_TIMEOUT_CYCLES = DDR_TIMEOUT_CYCLES_DEF
)(
   input  logic       i_clk,
   input  logic       i_nrst,
   input  logic       i_sys_locked,
   input  logic       i_ddr_calib_done,
   input  logic       i_dmireset,
   input  logic       i_sw_reset,
   output logic       o_sys_nrst,
   output logic       o_dbg_nrst,
   output logic       o_ddr_nrst,
   output logic       o_ddr_timeout,
   output logic [2:0] o_state,
   output logic [7:0] o_soft_rst_cnt
);

   localparam int unsigned CNT_W =
      $clog2(maxOf3(LOCK_FILTER_CYCLES, RST_HOLD_CYCLES, DDR_TIMEOUT_CYCLES));
   localparam logic [CNT_W-1:0] LOCK_LAST    = CNT_W'(LOCK_FILTER_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RST_HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(DDR_TIMEOUT_CYCLES - 1);

   logic             w_sLock;
   logic             w_sCalib;
   seq_state_t       r_state;
   logic [2:0]       r_nrstLevels;
   logic [CNT_W-1:0] r_cnt;
   logic             r_ddrTimeout;
   logic [7:0]       r_softRstCnt;

   cdc_sync2 u_syncLock (
      .i_clk  (i_clk),
      .i_nrst (i_nrst),
      .i_d    (i_sys_locked),
      .o_q    (w_sLock)
   );

   cdc_sync2 u_syncCalib (
      .i_clk  (i_clk),
      .i_nrst (i_nrst),
      .i_d    (i_ddr_calib_done),
      .o_q    (w_sCalib)
   );

   // Reset-net levels are registered alongside the state so they switch on the same edge.
   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         r_state      <= ST_WAIT_LOCK;
         r_nrstLevels <= 3'b000;
         r_cnt        <= '0;
         r_ddrTimeout <= 1'b0;
         r_softRstCnt <= '0;
      end else if (!w_sLock && (r_state != ST_WAIT_LOCK)) begin
         r_state      <= ST_WAIT_LOCK;
         r_nrstLevels <= nrstLevels(ST_WAIT_LOCK);
         r_cnt        <= '0;
      end else begin
         case (r_state)
            ST_WAIT_LOCK: begin
               if (!w_sLock) begin
                  r_cnt <= '0;
               end else if (r_cnt == LOCK_LAST) begin
                  r_state      <= ST_DDR_RST;
                  r_nrstLevels <= nrstLevels(ST_DDR_RST);
                  r_cnt        <= '0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            ST_DDR_RST: begin
               if (r_cnt == HOLD_LAST) begin
                  r_state      <= ST_DDR_CALIB;
                  r_nrstLevels <= nrstLevels(ST_DDR_CALIB);
                  r_cnt        <= '0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            ST_DDR_CALIB: begin
               if (w_sCalib) begin
                  r_state      <= ST_RUN;
                  r_nrstLevels <= nrstLevels(ST_RUN);
                  r_cnt        <= '0;
               end else if (r_cnt == TIMEOUT_LAST) begin
                  r_state      <= ST_ERR;
                  r_nrstLevels <= nrstLevels(ST_ERR);
                  r_cnt        <= '0;
                  r_ddrTimeout <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            // Calibration loss outranks a soft-reset request: DDR must be re-trained first.
            ST_RUN: begin
               if (!w_sCalib) begin
                  r_state      <= ST_DDR_RST;
                  r_nrstLevels <= nrstLevels(ST_DDR_RST);
                  r_cnt        <= '0;
               end else if (i_dmireset || i_sw_reset) begin
                  r_state      <= ST_SOFT_RST;
                  r_nrstLevels <= nrstLevels(ST_SOFT_RST);
                  r_cnt        <= '0;
                  if (r_softRstCnt != SOFT_RST_CNT_MAX) begin
                     r_softRstCnt <= r_softRstCnt + 1'b1;
                  end
               end
            end
            ST_SOFT_RST: begin
               if (r_cnt == HOLD_LAST) begin
                  if (!i_dmireset) begin
                     r_state      <= ST_RUN;
                     r_nrstLevels <= nrstLevels(ST_RUN);
                     r_cnt        <= '0;
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            ST_ERR: begin
               if (i_sw_reset) begin
                  r_state      <= ST_DDR_RST;
                  r_nrstLevels <= nrstLevels(ST_DDR_RST);
                  r_cnt        <= '0;
                  r_ddrTimeout <= 1'b0;
               end
            end
            default: begin
               r_state      <= ST_WAIT_LOCK;
               r_nrstLevels <= nrstLevels(ST_WAIT_LOCK);
               r_cnt        <= '0;
            end
         endcase
      end
   end

   assign o_sys_nrst     = r_nrstLevels[2];
   assign o_dbg_nrst     = r_nrstLevels[1];
   assign o_ddr_nrst     = r_nrstLevels[0];
   assign o_ddr_timeout  = r_ddrTimeout;
   assign o_state        = r_state;
   assign o_soft_rst_cnt = r_softRstCnt;

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: directed power-up/fault scenarios plus
// randomized run-time traffic, all compared against a phase/age reference model.
module tb_reset_sequencer;
   import reset_sequencer_pkg::*;

   localparam int LF = 16;
   localparam int RH = 32;
   localparam int TO = 100;

   logic       i_clk;
   logic       i_nrst;
   logic       i_sys_locked;
   logic       i_ddr_calib_done;
   logic       i_dmireset;
   logic       i_sw_reset;
   logic       o_sys_nrst;
   logic       o_dbg_nrst;
   logic       o_ddr_nrst;
   logic       o_ddr_timeout;
   logic [2:0] o_state;
   logic [7:0] o_soft_rst_cnt;

   int testCount = 0;
   int failCount = 0;

   reset_sequencer #(
      .LOCK_FILTER_CYCLES (LF),
      .RST_HOLD_CYCLES    (RH),
      .DDR_TIMEOUT_CYCLES (TO)
   ) dut (
      .i_clk            (i_clk),
      .i_nrst           (i_nrst),
      .i_sys_locked     (i_sys_locked),
      .i_ddr_calib_done (i_ddr_calib_done),
      .i_dmireset       (i_dmireset),
      .i_sw_reset       (i_sw_reset),
      .o_sys_nrst       (o_sys_nrst),
      .o_dbg_nrst       (o_dbg_nrst),
      .o_ddr_nrst       (o_ddr_nrst),
      .o_ddr_timeout    (o_ddr_timeout),
      .o_state          (o_state),
      .o_soft_rst_cnt   (o_soft_rst_cnt)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   // Reference model: synchronizer delay as a 2-deep history, lock filter as a
   // run length of synchronized highs, and each phase timed by its age since entry.
   seq_state_t mPhase;
   int         mAge;
   int         mLockRun;
   int         mSoftCnt;
   bit         mTimeout;
   bit         mLockD1, mLockD2, mCalibD1, mCalibD2;
   bit         mSl, mSc;

   function automatic logic [2:0] expLevels(input seq_state_t p);
      case (p)
         ST_DDR_RST:   return 3'b010;
         ST_DDR_CALIB: return 3'b011;
         ST_RUN:       return 3'b111;
         ST_SOFT_RST:  return 3'b011;
         ST_ERR:       return 3'b010;
         default:      return 3'b000;
      endcase
   endfunction

   always @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         mPhase = ST_WAIT_LOCK; mAge = 0; mLockRun = 0; mSoftCnt = 0; mTimeout = 1'b0;
         mLockD1 = 1'b0; mLockD2 = 1'b0; mCalibD1 = 1'b0; mCalibD2 = 1'b0;
      end else begin
         mSl = mLockD2;
         mSc = mCalibD2;
         mLockD2 = mLockD1;   mLockD1 = i_sys_locked;
         mCalibD2 = mCalibD1; mCalibD1 = i_ddr_calib_done;
         mLockRun = mSl ? mLockRun + 1 : 0;
         mAge = mAge + 1;
         if (!mSl) begin
            if (mPhase != ST_WAIT_LOCK) begin mPhase = ST_WAIT_LOCK; mAge = 0; end
         end else begin
            case (mPhase)
               ST_WAIT_LOCK:
                  if (mLockRun >= LF) begin mPhase = ST_DDR_RST; mAge = 0; end
               ST_DDR_RST:
                  if (mAge >= RH) begin mPhase = ST_DDR_CALIB; mAge = 0; end
               ST_DDR_CALIB:
                  if (mSc) begin mPhase = ST_RUN; mAge = 0; end
                  else if (mAge >= TO) begin mPhase = ST_ERR; mAge = 0; mTimeout = 1'b1; end
               ST_RUN:
                  if (!mSc) begin mPhase = ST_DDR_RST; mAge = 0; end
                  else if (i_dmireset || i_sw_reset) begin
                     mPhase = ST_SOFT_RST; mAge = 0;
                     mSoftCnt = (mSoftCnt < 255) ? mSoftCnt + 1 : 255;
                  end
               ST_SOFT_RST:
                  if (mAge >= RH && !i_dmireset) begin mPhase = ST_RUN; mAge = 0; end
               ST_ERR:
                  if (i_sw_reset) begin mPhase = ST_DDR_RST; mAge = 0; mTimeout = 1'b0; end
               default: begin mPhase = ST_WAIT_LOCK; mAge = 0; end
            endcase
         end
      end
   end

   function automatic logic [14:0] obsVec();
      return {o_state, o_sys_nrst, o_dbg_nrst, o_ddr_nrst, o_ddr_timeout, o_soft_rst_cnt};
   endfunction

   function automatic logic [14:0] expVec();
      return {mPhase, expLevels(mPhase), mTimeout, 8'(mSoftCnt)};
   endfunction

   task automatic checkOutput(input string tag, input logic [14:0] observed,
                              input logic [14:0] expected);
      testCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%h, expected 0x%h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic applyStimulus(input bit lock, input bit calib, input bit dmi,
                                input bit sw, input int cycles);
      i_sys_locked     = lock;
      i_ddr_calib_done = calib;
      i_dmireset       = dmi;
      i_sw_reset       = sw;
      for (int i = 0; i < cycles; i++) begin
         @(posedge i_clk);
         #1;
         checkOutput("model", obsVec(), expVec());
         i_sw_reset = 1'b0;
      end
   endtask

   initial begin
      i_nrst = 1'b1; i_sys_locked = 1'b0; i_ddr_calib_done = 1'b0;
      i_dmireset = 1'b0; i_sw_reset = 1'b0;
      #2 i_nrst = 1'b0;
      #1 checkOutput("resetState", obsVec(), 15'd0);
      repeat (3) @(posedge i_clk);
      #1 i_nrst = 1'b1;

      // Power-up with default-style timing: dbg at +18, ddr at +50, sys 3 after calib.
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 17);
      checkOutput("dbgBefore18", 15'(o_dbg_nrst), 15'd0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1);
      checkOutput("dbgAt18", 15'(o_dbg_nrst), 15'd1);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 31);
      checkOutput("ddrBefore50", 15'(o_ddr_nrst), 15'd0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1);
      checkOutput("ddrAt50", 15'(o_ddr_nrst), 15'd1);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 9);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 2);
      checkOutput("sysBeforeCalib3", 15'(o_sys_nrst), 15'd0);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1);
      checkOutput("sysAfterCalib3", 15'(o_sys_nrst), 15'd1);
      checkOutput("stateRun", 15'(o_state), 15'd3);

      // Soft reset by software pulse, then by a long debug-module request.
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1);
      checkOutput("softEnter", 15'({o_state, o_sys_nrst, o_dbg_nrst, o_ddr_nrst}), 15'b100_0_1_1);
      checkOutput("softCnt1", 15'(o_soft_rst_cnt), 15'd1);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 31);
      checkOutput("softHold", 15'(o_sys_nrst), 15'd0);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1);
      checkOutput("softDone", 15'(o_state), 15'd3);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 100);
      checkOutput("dmiHold", 15'(o_sys_nrst), 15'd0);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1);
      checkOutput("dmiRelease", 15'(o_state), 15'd3);
      checkOutput("softCnt2", 15'(o_soft_rst_cnt), 15'd2);

      // Lock loss reaching the FSM in the same cycle as a software pulse.
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 2);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1);
      checkOutput("lockBeatsSw", 15'(o_state), 15'd0);
      checkOutput("lockBeatsSwCnt", 15'(o_soft_rst_cnt), 15'd2);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 60);
      checkOutput("relockRun", 15'(o_state), 15'd3);

      // Calibration loss in RUN, then a timeout in DDR_CALIB and recovery from ERR.
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 3);
      checkOutput("calibDrop", 15'({o_state, o_sys_nrst}), 15'b001_0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32 + 99);
      checkOutput("calibWait", 15'(o_state), 15'd2);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1);
      checkOutput("timeout", 15'({o_state, o_ddr_timeout}), 15'b101_1);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 5);
      checkOutput("errIgnoresDmi", 15'(o_state), 15'd5);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1);
      checkOutput("errRecover", 15'({o_state, o_ddr_timeout}), 15'b001_0);

      // Asynchronous reset in the middle of DDR_RST.
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 10);
      #1 i_nrst = 1'b0;
      #1 checkOutput("asyncReset", obsVec(), 15'd0);
      i_sys_locked = 1'b0;
      repeat (2) @(posedge i_clk);
      #1 i_nrst = 1'b1;

      // A short lock glitch must restart the filter.
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 20);
      checkOutput("glitchHold", 15'({o_state, o_sys_nrst, o_dbg_nrst, o_ddr_nrst}), 15'd0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 17);
      checkOutput("glitchDbgBefore", 15'(o_dbg_nrst), 15'd0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1);
      checkOutput("glitchDbgAt18", 15'(o_dbg_nrst), 15'd1);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 37);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 5);
      checkOutput("glitchRun", 15'(o_state), 15'd3);

      // Counter saturation.
      for (int n = 0; n < 300; n++) begin
         applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1);
         applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, RH + 1);
      end
      checkOutput("saturate", 15'(o_soft_rst_cnt), 15'd255);

      // Randomized run-time traffic against the model.
      for (int n = 0; n < 200; n++) begin
         applyStimulus($urandom_range(0, 19) != 0, $urandom_range(0, 9) != 0,
                       $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
                       int'($urandom_range(1, 40)));
      end

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
